pong_match_ctrl: RTL and testbench

Match sequencer for the Pong game. It drives the shared animate enable and object reset of the paddles and ball, and keeps both players' scores. It runs the serve countdown, live play, pause, point freeze and game-over phases. It sits between the button inputs, the ball's miss detectors and the animated objects, and its state and scores feed the score display.

---
 rtl/pong_match_ctrl_if.sv | 30 +++
 rtl/pong_match_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the Pong match sequencer and its surroundings:
// buttons, miss detectors and strobe in; object control and score state out.
interface pong_match_ctrl_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               i_ani_stb;
  logic               i_start;
  logic               i_miss_top;
  logic               i_miss_bot;
  logic               o_animate;
  logic               o_obj_rst;
  logic [2:0]         o_state;
  logic [SCORE_W-1:0] o_score_top;
  logic [SCORE_W-1:0] o_score_bot;
  logic               o_serve_dir;
  logic               o_point;
  logic               o_winner;

  modport master (
    output i_ani_stb, i_start, i_miss_top, i_miss_bot,
    input  o_animate, o_obj_rst, o_state, o_score_top, o_score_bot,
           o_serve_dir, o_point, o_winner
  );

  modport slave (
    input  i_ani_stb, i_start, i_miss_top, i_miss_bot,
    output o_animate, o_obj_rst, o_state, o_score_top, o_score_bot,
           o_serve_dir, o_point, o_winner
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, live play, pause, point freeze and
// game over, plus both players' scores. All outputs come straight from flops.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned SCORE_W      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  pong_match_ctrl_if.slave     bus
);

  localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned CNT_W      = $clog2(MAX_FRAMES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q, start_d;
  logic [SCORE_W-1:0] score_top_q, score_top_d;
  logic [SCORE_W-1:0] score_bot_q, score_bot_d;
  logic               serve_dir_q, serve_dir_d;
  logic               point_q, point_d;
  logic               winner_q, winner_d;
  logic               animate_q, animate_d;
  logic               obj_rst_q, obj_rst_d;

  logic start_edge;
  logic last_frame;
  logic any_miss;
  logic win_reached;

  assign start_edge  = bus.i_start & ~start_q;
  assign last_frame  = bus.i_ani_stb && (cnt_q == CNT_W'(1));
  assign any_miss    = bus.i_miss_top | bus.i_miss_bot;
  assign win_reached = (score_top_q == SCORE_W'(WIN_SCORE)) ||
                       (score_bot_q == SCORE_W'(WIN_SCORE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      score_top_q <= '0;
      score_bot_q <= '0;
      serve_dir_q <= 1'b1;
      point_q     <= 1'b0;
      winner_q    <= 1'b0;
      animate_q   <= 1'b0;
      obj_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      score_top_q <= score_top_d;
      score_bot_q <= score_bot_d;
      serve_dir_q <= serve_dir_d;
      point_q     <= point_d;
      winner_q    <= winner_d;
      animate_q   <= animate_d;
      obj_rst_q   <= obj_rst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_d     = bus.i_start;
    score_top_d = score_top_q;
    score_bot_d = score_bot_q;
    serve_dir_d = serve_dir_q;
    point_d     = 1'b0;
    winner_d    = winner_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d     = ST_SERVE;
          score_top_d = '0;
          score_bot_d = '0;
          cnt_d       = CNT_W'(SERVE_FRAMES);
        end
      end

      ST_SERVE: begin
        if (bus.i_ani_stb) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (last_frame) state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // A miss outranks a simultaneous start edge; a double miss is a draw.
        if (any_miss) begin
          point_d = 1'b1;
          cnt_d   = CNT_W'(POINT_FRAMES);
          state_d = ST_POINT;
          if (bus.i_miss_top && !bus.i_miss_bot) begin
            score_bot_d = score_bot_q + SCORE_W'(1);
            serve_dir_d = 1'b0;
          end else if (bus.i_miss_bot && !bus.i_miss_top) begin
            score_top_d = score_top_q + SCORE_W'(1);
            serve_dir_d = 1'b1;
          end
        end else if (start_edge) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (start_edge) state_d = ST_PLAY;
      end

      ST_POINT: begin
        if (bus.i_ani_stb) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (last_frame) begin
            if (win_reached) begin
              winner_d = (score_bot_q == SCORE_W'(WIN_SCORE));
              state_d  = ST_OVER;
            end else begin
              cnt_d   = CNT_W'(SERVE_FRAMES);
              state_d = ST_SERVE;
            end
          end
        end
      end

      ST_OVER: begin
        if (start_edge) begin
          state_d     = ST_SERVE;
          score_top_d = '0;
          score_bot_d = '0;
          cnt_d       = CNT_W'(SERVE_FRAMES);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Object controls follow the next state so they line up with o_state.
    animate_d = (state_d == ST_PLAY);
    obj_rst_d = (state_d == ST_IDLE) ||
                ((state_d == ST_SERVE) && (state_q != ST_SERVE));
  end

  assign bus.o_state     = state_q;
  assign bus.o_animate   = animate_q;
  assign bus.o_obj_rst   = obj_rst_q;
  assign bus.o_score_top = score_top_q;
  assign bus.o_score_bot = score_bot_q;
  assign bus.o_serve_dir = serve_dir_q;
  assign bus.o_point     = point_q;
  assign bus.o_winner    = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with small frame counts and WIN_SCORE=2.
module tb_pong_match_ctrl;

  localparam int unsigned WIN_SCORE    = 2;
  localparam int unsigned SERVE_FRAMES = 3;
  localparam int unsigned POINT_FRAMES = 2;
  localparam int unsigned SCORE_W      = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  pong_match_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  pong_match_ctrl #(
    .WIN_SCORE   (WIN_SCORE),
    .SERVE_FRAMES(SERVE_FRAMES),
    .POINT_FRAMES(POINT_FRAMES),
    .SCORE_W     (SCORE_W)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Advance one clock; inputs set afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    bus.i_ani_stb = 1'b1;
    tick();
    bus.i_ani_stb = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int k = 0; k < n; k++) strobe();
  endtask

  task automatic start_press();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.i_ani_stb  = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_miss_top = 1'b0;
    bus.i_miss_bot = 1'b0;
    #12;

    // Reset values
    check_eq("rst_state",  32'(bus.o_state), 32'd0);
    check_eq("rst_objrst", 32'(bus.o_obj_rst), 32'd1);
    check_eq("rst_anim",   32'(bus.o_animate), 32'd0);
    check_eq("rst_stop",   32'(bus.o_score_top), 32'd0);
    check_eq("rst_sbot",   32'(bus.o_score_bot), 32'd0);
    check_eq("rst_dir",    32'(bus.o_serve_dir), 32'd1);
    check_eq("rst_point",  32'(bus.o_point), 32'd0);
    check_eq("rst_win",    32'(bus.o_winner), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("idle_hold", 32'(bus.o_state), 32'd0);

    // 1: start -> SERVE with single obj_rst pulse, 3 strobes -> PLAY
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check_eq("t1_serve",    32'(bus.o_state), 32'd1);
    check_eq("t1_objrst_h", 32'(bus.o_obj_rst), 32'd1);
    tick();
    check_eq("t1_objrst_l", 32'(bus.o_obj_rst), 32'd0);
    bus.i_miss_top = 1'b1;
    strobes(2);
    bus.i_miss_top = 1'b0;
    check_eq("t1_serve2",   32'(bus.o_state), 32'd1);
    check_eq("t1_sbot_ign", 32'(bus.o_score_bot), 32'd0);
    check_eq("t1_anim0",    32'(bus.o_animate), 32'd0);
    strobe();
    check_eq("t1_play",  32'(bus.o_state), 32'd2);
    check_eq("t1_anim1", 32'(bus.o_animate), 32'd1);

    // 2: top miss -> bottom scores
    bus.i_miss_top = 1'b1;
    tick();
    bus.i_miss_top = 1'b0;
    check_eq("t2_point", 32'(bus.o_point), 32'd1);
    check_eq("t2_sbot",  32'(bus.o_score_bot), 32'd1);
    check_eq("t2_stop",  32'(bus.o_score_top), 32'd0);
    check_eq("t2_dir",   32'(bus.o_serve_dir), 32'd0);
    check_eq("t2_state", 32'(bus.o_state), 32'd4);
    check_eq("t2_anim",  32'(bus.o_animate), 32'd0);
    tick();
    check_eq("t2_point_l", 32'(bus.o_point), 32'd0);
    strobe();
    check_eq("t2_frozen", 32'(bus.o_state), 32'd4);
    strobe();
    check_eq("t2_serve",  32'(bus.o_state), 32'd1);
    check_eq("t2_objrst", 32'(bus.o_obj_rst), 32'd1);
    strobes(3);
    check_eq("t2_play", 32'(bus.o_state), 32'd2);

    // 3: simultaneous misses -> draw
    bus.i_miss_top = 1'b1;
    bus.i_miss_bot = 1'b1;
    tick();
    bus.i_miss_top = 1'b0;
    bus.i_miss_bot = 1'b0;
    check_eq("t3_point", 32'(bus.o_point), 32'd1);
    check_eq("t3_state", 32'(bus.o_state), 32'd4);
    check_eq("t3_stop",  32'(bus.o_score_top), 32'd0);
    check_eq("t3_sbot",  32'(bus.o_score_bot), 32'd1);
    check_eq("t3_dir",   32'(bus.o_serve_dir), 32'd0);
    strobes(2);
    strobes(3);
    check_eq("t3_play", 32'(bus.o_state), 32'd2);

    // 5: pause, misses ignored, resume
    bus.i_start = 1'b1;
    tick();
    check_eq("t5_pause", 32'(bus.o_state), 32'd3);
    check_eq("t5_anim",  32'(bus.o_animate), 32'd0);
    bus.i_miss_bot = 1'b1;
    tick();
    bus.i_miss_bot = 1'b0;
    bus.i_start = 1'b0;
    check_eq("t5_held",  32'(bus.o_state), 32'd3);
    check_eq("t5_stop",  32'(bus.o_score_top), 32'd0);
    check_eq("t5_point", 32'(bus.o_point), 32'd0);
    tick();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check_eq("t5_resume", 32'(bus.o_state), 32'd2);
    check_eq("t5_anim1",  32'(bus.o_animate), 32'd1);
    tick();

    // 4: miss together with start edge -> miss wins, bottom reaches 2 -> OVER
    bus.i_start = 1'b1;
    bus.i_miss_top = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_miss_top = 1'b0;
    check_eq("t4_state", 32'(bus.o_state), 32'd4);
    check_eq("t4_sbot",  32'(bus.o_score_bot), 32'd2);
    strobes(2);
    check_eq("t4_over",   32'(bus.o_state), 32'd5);
    check_eq("t4_winner", 32'(bus.o_winner), 32'd1);
    check_eq("t4_stop",   32'(bus.o_score_top), 32'd0);
    check_eq("t4_objrst", 32'(bus.o_obj_rst), 32'd0);
    bus.i_miss_bot = 1'b1;
    strobes(3);
    bus.i_miss_bot = 1'b0;
    check_eq("t4_over_hold", 32'(bus.o_state), 32'd5);
    check_eq("t4_sbot_hold", 32'(bus.o_score_bot), 32'd2);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check_eq("t4_restart", 32'(bus.o_state), 32'd1);
    check_eq("t4_clr_bot", 32'(bus.o_score_bot), 32'd0);
    check_eq("t4_clr_top", 32'(bus.o_score_top), 32'd0);
    check_eq("t4_dir",     32'(bus.o_serve_dir), 32'd0);
    check_eq("t4_objrst1", 32'(bus.o_obj_rst), 32'd1);

    // 6: async reset mid-SERVE
    strobe();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_state",  32'(bus.o_state), 32'd0);
    check_eq("t6_async_objrst", 32'(bus.o_obj_rst), 32'd1);
    check_eq("t6_async_dir",    32'(bus.o_serve_dir), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // 6: held start gives one transition only, and no pause once in PLAY
    bus.i_start = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check_eq("t6_held_serve", 32'(bus.o_state), 32'd1);
    strobes(3);
    tick();
    check_eq("t6_held_play", 32'(bus.o_state), 32'd2);
    bus.i_start = 1'b0;
    tick();
    check_eq("t6_still_play", 32'(bus.o_state), 32'd2);
    start_press();
    check_eq("t6_pause", 32'(bus.o_state), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
